// File: rtl/bounce_pkg.sv
// bounce_pkg: shared types, defaults and the clamped axis-step helper for the sprite engine
package bounce_pkg;
  localparam int SPRITE_W  = 6;
  localparam int DEF_H_RES = 640;
  localparam int DEF_V_RES = 480;
  typedef enum logic {IDLE, UPDATE} state_t;
  // Moves one axis by s and clamps it into [0,lim]; returns {pos, dir}, where dir=1 means moving +
  function automatic logic [10:0] step_axis(input logic [9:0] pos, input logic dir,
                                            input logic [9:0] s, input logic [9:0] lim);
    logic signed [11:0] n;
    n = dir ? $signed({2'b00, pos}) + $signed({2'b00, s}) : $signed({2'b00, pos}) - $signed({2'b00, s});
    return (n <= 12'sd0) ? {10'd0, 1'b1} : (n >= $signed({2'b00, lim})) ? {lim, 1'b0} : {n[9:0], dir};
  endfunction
endpackage

// File: rtl/bounce_sprite_engine_hit.sv
// sprite_hit_test: tests whether the current pixel lies inside one SIZE x SIZE sprite box
module sprite_hit_test
  import bounce_pkg::*;
#(
  parameter int SIZE = 64
) (
  input  logic [9:0] i_x,
  input  logic [9:0] i_y,
  input  logic [9:0] i_px,
  input  logic [9:0] i_py,
  output logic       o_hit
);
  logic w_in_x, w_in_y;
  // Upper bounds are formed one bit wider so x+SIZE can never wrap
  assign w_in_x = (i_px >= i_x) && ({1'b0, i_px} < {1'b0, i_x} + 11'(SIZE));
  assign w_in_y = (i_py >= i_y) && ({1'b0, i_py} < {1'b0, i_y} + 11'(SIZE));
  assign o_hit  = w_in_x && w_in_y;
endmodule

// File: rtl/bounce_sprite_engine.sv
// bounce_sprite_engine: N bouncing squares with per-frame motion, priority compositing and overlap flags
module bounce_sprite_engine
  import bounce_pkg::*;
#(
  parameter int          N_SPRITES = 5,
  parameter int          SIZE      = 64,
  parameter int          H_RES     = DEF_H_RES,
  parameter int          V_RES     = DEF_V_RES,
  parameter int          STEP_X    = 3,
  parameter int          STEP_Y    = 6,
  parameter logic [47:0] COLORS    = {6'h2A, 6'h3F, 6'h33, 6'h0F, 6'h3C, 6'h03, 6'h0C, 6'h30}
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_tick,
  input  logic                  pause,
  input  logic [1:0]            speed,
  input  logic                  display_on,
  input  logic [9:0]            pix_x,
  input  logic [9:0]            pix_y,
  output logic [SPRITE_W-1:0]   rgb,
  output logic                  hit,
  output logic [N_SPRITES-1:0]  collide,
  output logic                  update_busy,
  output logic                  overrun
);
  localparam logic [9:0] LIM_X = 10'(H_RES - SIZE);
  localparam logic [9:0] LIM_Y = 10'(V_RES - SIZE);
  state_t                r_state;
  logic [2:0]            r_idx;
  logic [9:0]            r_x [N_SPRITES];
  logic [9:0]            r_y [N_SPRITES];
  logic [N_SPRITES-1:0]  r_dx, r_dy;
  logic [1:0]            w_sh;
  logic [9:0]            w_sx, w_sy;
  logic [10:0]           w_nx, w_ny;
  logic [N_SPRITES-1:0]  w_hit;
  logic [SPRITE_W-1:0]   w_rgb;
  logic [3:0]            w_cnt;

  // Single shared step datapath, addressed by the walk index; speed 3 saturates to x4
  assign w_sh = speed[1] ? 2'd2 : speed;
  assign w_sx = 10'((STEP_X + int'(r_idx)) << w_sh);
  assign w_sy = 10'((STEP_Y + int'(r_idx)) << w_sh);
  assign w_nx = step_axis(r_x[r_idx], r_dx[r_idx], w_sx, LIM_X);
  assign w_ny = step_axis(r_y[r_idx], r_dy[r_idx], w_sy, LIM_Y);

  for (genvar i = 0; i < N_SPRITES; i++) begin : g_spr
    sprite_hit_test #(.SIZE(SIZE)) u_hit (
      .i_x  (r_x[i]),
      .i_y  (r_y[i]),
      .i_px (pix_x),
      .i_py (pix_y),
      .o_hit(w_hit[i])
    );
  end

  // Lowest-index covering sprite wins the pixel; also count how many sprites cover it
  always_comb begin
    w_rgb = '0;
    w_cnt = '0;
    for (int k = N_SPRITES - 1; k >= 0; k--) begin
      w_rgb = w_hit[k] ? COLORS[SPRITE_W*k +: SPRITE_W] : w_rgb;
      w_cnt = w_cnt + 4'(w_hit[k]);
    end
  end

  // Update walk: one sprite per cycle after an unpaused frame tick; pause skips the move but not the walk
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      update_busy <= 1'b0;
      overrun     <= 1'b0;
      for (int k = 0; k < N_SPRITES; k++) begin
        r_x[k]  <= 10'((97 * k) % (H_RES - SIZE));
        r_y[k]  <= 10'((61 * k) % (V_RES - SIZE));
        r_dx[k] <= 1'(k % 2);
        r_dy[k] <= 1'((k + 1) % 2);
      end
    end else if (r_state == IDLE) begin
      if (frame_tick && !pause) begin
        r_state     <= UPDATE;
        r_idx       <= '0;
        update_busy <= 1'b1;
      end
    end else begin
      if (frame_tick) overrun <= 1'b1;
      if (!pause) begin
        r_x[r_idx]  <= w_nx[10:1];
        r_dx[r_idx] <= w_nx[0];
        r_y[r_idx]  <= w_ny[10:1];
        r_dy[r_idx] <= w_ny[0];
      end
      if (int'(r_idx) == N_SPRITES - 1) begin
        r_state     <= IDLE;
        r_idx       <= '0;
        update_busy <= 1'b0;
      end else begin
        r_idx <= r_idx + 3'd1;
      end
    end
  end

  // Registered pixel output, blanked outside the visible area
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb <= '0;
      hit <= 1'b0;
    end else begin
      rgb <= display_on ? w_rgb : '0;
      hit <= display_on && (|w_hit);
    end
  end

  // Sticky overlap flags for the frame; a frame tick clears them and beats a same-cycle set
  always_ff @(posedge clk or posedge reset) begin
    if (reset) collide <= '0;
    else collide <= frame_tick ? '0 : (display_on && w_cnt >= 4'd2) ? (collide | w_hit) : collide;
  end
endmodule
